// File: rtl/amux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// amux_scan_sequencer
//
// Drives the complementary P/N transmission-gate enables of an 8:1 analog
// input mux. Supports manual single-channel selection and round-robin
// scanning over a channel mask. Every switch change goes through an all-off
// break interval (BBM_CYCLES) and a programmable settle interval before
// the mux output is reported valid.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   cfg_en       - sequencer enable; 0 opens all switches
//   cfg_scan     - 0 = manual (cfg_chan), 1 = scan (cfg_mask)
//   cfg_chan     - manual-mode channel index
//   cfg_mask     - scan-mode channel enable mask (bit i = channel i)
//   cfg_settle   - settle cycles after connect, minus 1 (sampled on SETTLE entry)
//   cfg_dwell    - scan hold cycles per channel, minus 1 (sampled on HOLD entry)
//   sw_p / sw_n  - one-hot P enables and their bitwise inverse
//   cur_chan     - channel targeted / connected
//   valid        - connected channel is settled (state HOLD)
//   sample       - pulse on the first HOLD cycle of each connection
//   wrap         - pulse when the scan moves to a lower-or-equal channel
//
// All outputs are registered from the next-state values, so they change on
// the same edge as the state register.
// ---------------------------------------------------------------------------
module amux_scan_sequencer #(
    parameter int BBM_CYCLES = 2,
    parameter int DWELL_W    = 16,
    parameter int SETTLE_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_en,
    input  logic                cfg_scan,
    input  logic [2:0]          cfg_chan,
    input  logic [7:0]          cfg_mask,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    output logic [7:0]          sw_p,
    output logic [7:0]          sw_n,
    output logic [2:0]          cur_chan,
    output logic                valid,
    output logic                sample,
    output logic                wrap
);

    localparam int BBM_W = $clog2(BBM_CYCLES) + 1;
    localparam logic [BBM_W-1:0] BBM_LOAD = BBM_W'(BBM_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BREAK  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cur_q, cur_d;
    logic [BBM_W-1:0]    bbm_q, bbm_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                scan_q;
    logic [7:0]          sw_p_d;
    logic                valid_d, sample_d, wrap_d;
    logic                go_break;
    logic [2:0]          tgt;
    logic [2:0]          lowest;
    logic [2:0]          nxt;

    // Lowest set bit of the mask (0 when the mask is empty).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Lowest set bit strictly above c, falling back to the lowest set bit.
    function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] c);
        logic [2:0] r;
        r = lowest_set(m);
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) r = 3'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        bbm_d    = bbm_q;
        settle_d = settle_q;
        dwell_d  = dwell_q;
        sample_d = 1'b0;
        wrap_d   = 1'b0;
        go_break = 1'b0;
        tgt      = cur_q;
        lowest   = lowest_set(cfg_mask);
        nxt      = next_above(cfg_mask, cur_q);

        if (!cfg_en) begin
            state_d = ST_IDLE;
        end else if (cfg_scan && (cfg_mask == 8'h00)) begin
            state_d = ST_IDLE;
        end else if ((state_q != ST_IDLE) && (cfg_scan != scan_q)) begin
            // Mode switched while active: reconnect using the new mode's target.
            go_break = 1'b1;
            tgt      = cfg_scan ? lowest : cfg_chan;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Empty scan mask was already filtered above.
                    go_break = 1'b1;
                    tgt      = cfg_scan ? lowest : cfg_chan;
                end
                ST_BREAK: begin
                    if (!cfg_scan && (cfg_chan != cur_q)) begin
                        go_break = 1'b1;
                        tgt      = cfg_chan;
                    end else if (bbm_q == '0) begin
                        state_d  = ST_SETTLE;
                        settle_d = cfg_settle;
                    end else begin
                        bbm_d = bbm_q - BBM_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (!cfg_scan && (cfg_chan != cur_q)) begin
                        go_break = 1'b1;
                        tgt      = cfg_chan;
                    end else if (settle_q == '0) begin
                        state_d  = ST_HOLD;
                        dwell_d  = cfg_dwell;
                        sample_d = 1'b1;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!cfg_scan) begin
                        if (cfg_chan != cur_q) begin
                            go_break = 1'b1;
                            tgt      = cfg_chan;
                        end
                    end else if (dwell_q == '0) begin
                        wrap_d = (nxt <= cur_q);
                        if (nxt != cur_q) begin
                            go_break = 1'b1;
                            tgt      = nxt;
                        end else begin
                            // Single-channel mask: stay connected, start a new dwell.
                            dwell_d  = cfg_dwell;
                            sample_d = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (go_break) begin
            state_d = ST_BREAK;
            cur_d   = tgt;
            bbm_d   = BBM_LOAD;
        end

        sw_p_d  = ((state_d == ST_SETTLE) || (state_d == ST_HOLD)) ? (8'd1 << cur_d) : 8'h00;
        valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cur_q    <= 3'd0;
            bbm_q    <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
            scan_q   <= 1'b0;
            sw_p     <= 8'h00;
            sw_n     <= 8'hFF;
            valid    <= 1'b0;
            sample   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            bbm_q    <= bbm_d;
            settle_q <= settle_d;
            dwell_q  <= dwell_d;
            scan_q   <= cfg_scan;
            sw_p     <= sw_p_d;
            sw_n     <= ~sw_p_d;
            valid    <= valid_d;
            sample   <= sample_d;
            wrap     <= wrap_d;
        end
    end

    assign cur_chan = cur_q;

endmodule

// File: tb/tb_amux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_amux_scan_sequencer
//
// Directed bench for amux_scan_sequencer (BBM_CYCLES=2). A linear sequence of
// steps drives the config inputs one cycle at a time; outputs are sampled 1ns
// after each rising edge. A negedge monitor checks the switch invariants
// (sw_n inverse, at most one bit, break-before-make gap) every cycle.
// ---------------------------------------------------------------------------
module tb_amux_scan_sequencer;

    localparam int BBM = 2;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic        cfg_scan;
    logic [2:0]  cfg_chan;
    logic [7:0]  cfg_mask;
    logic [7:0]  cfg_settle;
    logic [15:0] cfg_dwell;
    logic [7:0]  sw_p;
    logic [7:0]  sw_n;
    logic [2:0]  cur_chan;
    logic        valid;
    logic        sample;
    logic        wrap;

    int n_cmp = 0;
    int n_err = 0;

    amux_scan_sequencer #(
        .BBM_CYCLES(BBM),
        .DWELL_W   (16),
        .SETTLE_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_scan  (cfg_scan),
        .cfg_chan  (cfg_chan),
        .cfg_mask  (cfg_mask),
        .cfg_settle(cfg_settle),
        .cfg_dwell (cfg_dwell),
        .sw_p      (sw_p),
        .sw_n      (sw_n),
        .cur_chan  (cur_chan),
        .valid     (valid),
        .sample    (sample),
        .wrap      (wrap)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a sample pulse (bounded). Reports cycles taken, wrap
    // pulses seen (including the final cycle), cycles with sw_p==0, and valid
    // cycles before the sample cycle.
    task automatic wait_sample(input int max_c, output int cyc, output int wraps,
                               output int zeros, output int vbefore);
        cyc = 0; wraps = 0; zeros = 0; vbefore = 0;
        forever begin
            tick();
            cyc++;
            if (wrap) wraps++;
            if (sw_p == 8'h00) zeros++;
            if (sample) break;
            if (valid) vbefore++;
            if (cyc >= max_c) break;
        end
    endtask

    // Invariant monitor: inverse rails, one-hot, break-before-make gap.
    logic [7:0] last_sw = 8'h00;
    int         zero_run = 0;
    always @(negedge clk) begin
        chk("inv_sw_n", {24'd0, sw_n}, {24'd0, ~sw_p});
        chk("onehot", ($countones(sw_p) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (sw_p == 8'h00) begin
            zero_run++;
        end else begin
            if ((last_sw != 8'h00) && (sw_p != last_sw))
                chk("bbm_gap", (zero_run >= BBM) ? 32'd1 : 32'd0, 32'd1);
            last_sw  = sw_p;
            zero_run = 0;
        end
    end

    int cyc, wr, zr, vb;

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_scan = 1'b0; cfg_chan = 3'd0;
        cfg_mask = 8'h00; cfg_settle = 8'd3; cfg_dwell = 16'd9;
        tick(); tick();
        chk("rst_sw_p", {24'd0, sw_p}, 32'h00);
        chk("rst_sw_n", {24'd0, sw_n}, 32'hFF);
        chk("rst_cur", {29'd0, cur_chan}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_sample", {31'd0, sample}, 0);
        chk("rst_wrap", {31'd0, wrap}, 0);
        rst = 1'b0;
        tick();

        // Manual ch3, settle=3: BREAK cycles 1-2, connect cycle 3, HOLD cycle 7.
        cfg_en = 1'b1; cfg_chan = 3'd3;
        tick();  // cycle 1
        chk("m3_c1_sw_p", {24'd0, sw_p}, 32'h00);
        tick();  // cycle 2
        chk("m3_c2_sw_p", {24'd0, sw_p}, 32'h00);
        chk("m3_c2_cur", {29'd0, cur_chan}, 3);
        tick();  // cycle 3
        chk("m3_c3_sw_p", {24'd0, sw_p}, 32'h08);
        chk("m3_c3_sw_n", {24'd0, sw_n}, 32'hF7);
        tick(); tick(); tick();  // cycle 6
        chk("m3_c6_valid", {31'd0, valid}, 0);
        chk("m3_c6_sw_p", {24'd0, sw_p}, 32'h08);
        tick();  // cycle 7
        chk("m3_c7_valid", {31'd0, valid}, 1);
        chk("m3_c7_sample", {31'd0, sample}, 1);
        tick();
        chk("m3_c8_sample", {31'd0, sample}, 0);
        chk("m3_c8_valid", {31'd0, valid}, 1);

        // Manual retarget 3 -> 5 from HOLD.
        cfg_chan = 3'd5;
        tick();
        chk("m5_b1_sw_p", {24'd0, sw_p}, 32'h00);
        chk("m5_b1_valid", {31'd0, valid}, 0);
        chk("m5_b1_cur", {29'd0, cur_chan}, 5);
        tick();
        chk("m5_b2_sw_p", {24'd0, sw_p}, 32'h00);
        tick();
        chk("m5_conn_sw_p", {24'd0, sw_p}, 32'h20);
        wait_sample(40, cyc, wr, zr, vb);
        chk("m5_hold_cyc", cyc, 4);
        chk("m5_hold_cur", {29'd0, cur_chan}, 5);

        // Scan mask 1000_0101, dwell 9: visits 0,2,7,0.
        cfg_scan = 1'b1; cfg_mask = 8'b1000_0101;
        wait_sample(60, cyc, wr, zr, vb);
        chk("s0_cyc", cyc, 7);
        chk("s0_zeros", zr, 2);
        chk("s0_cur", {29'd0, cur_chan}, 0);
        chk("s0_sw_p", {24'd0, sw_p}, 32'h01);
        wait_sample(60, cyc, wr, zr, vb);
        chk("s2_cyc", cyc, 16);
        chk("s2_hold_len", vb + 1, 10);
        chk("s2_wraps", wr, 0);
        chk("s2_zeros", zr, 2);
        chk("s2_cur", {29'd0, cur_chan}, 2);
        chk("s2_sw_p", {24'd0, sw_p}, 32'h04);
        wait_sample(60, cyc, wr, zr, vb);
        chk("s7_cyc", cyc, 16);
        chk("s7_wraps", wr, 0);
        chk("s7_cur", {29'd0, cur_chan}, 7);
        chk("s7_sw_p", {24'd0, sw_p}, 32'h80);
        wait_sample(60, cyc, wr, zr, vb);
        chk("s0b_cyc", cyc, 16);
        chk("s0b_hold_len", vb + 1, 10);
        chk("s0b_wraps", wr, 1);
        chk("s0b_cur", {29'd0, cur_chan}, 0);

        // Mask change takes effect at next selection; then single channel 4.
        cfg_mask = 8'h10;
        tick();
        chk("s4_pre_sw_p", {24'd0, sw_p}, 32'h01);
        wait_sample(60, cyc, wr, zr, vb);
        chk("s4_cyc", cyc + 1, 16);
        chk("s4_wraps", wr, 0);
        chk("s4_cur", {29'd0, cur_chan}, 4);
        for (int k = 0; k < 2; k++) begin
            wait_sample(60, cyc, wr, zr, vb);
            chk("single_cyc", cyc, 10);
            chk("single_wraps", wr, 1);
            chk("single_zeros", zr, 0);
            chk("single_valid", vb, 9);
            chk("single_sw_p", {24'd0, sw_p}, 32'h10);
        end

        // Empty mask during HOLD -> IDLE; restore 8'h02 -> ch1 via BREAK.
        cfg_mask = 8'h00;
        tick();
        chk("empty_sw_p", {24'd0, sw_p}, 32'h00);
        chk("empty_sw_n", {24'd0, sw_n}, 32'hFF);
        chk("empty_valid", {31'd0, valid}, 0);
        tick();
        chk("empty_stay", {24'd0, sw_p}, 32'h00);
        cfg_mask = 8'h02;
        wait_sample(60, cyc, wr, zr, vb);
        chk("s1_cyc", cyc, 7);
        chk("s1_zeros", zr, 2);
        chk("s1_cur", {29'd0, cur_chan}, 1);
        chk("s1_sw_p", {24'd0, sw_p}, 32'h02);

        // Back to manual ch6, drop cfg_en mid-SETTLE.
        cfg_scan = 1'b0; cfg_chan = 3'd6;
        tick(); tick();
        chk("m6_break_sw_p", {24'd0, sw_p}, 32'h00);
        tick(); tick();
        chk("m6_settle_sw_p", {24'd0, sw_p}, 32'h40);
        cfg_en = 1'b0;
        tick();
        chk("dis_sw_p", {24'd0, sw_p}, 32'h00);
        chk("dis_sw_n", {24'd0, sw_n}, 32'hFF);
        chk("dis_valid", {31'd0, valid}, 0);
        cfg_en = 1'b1;
        wait_sample(60, cyc, wr, zr, vb);
        chk("m6_cyc", cyc, 7);
        chk("m6_cur", {29'd0, cur_chan}, 6);
        tick();

        // Reset mid-HOLD, then restart from BREAK with cfg_en held high.
        rst = 1'b1;
        tick();
        chk("mrst_sw_p", {24'd0, sw_p}, 32'h00);
        chk("mrst_sw_n", {24'd0, sw_n}, 32'hFF);
        chk("mrst_valid", {31'd0, valid}, 0);
        chk("mrst_cur", {29'd0, cur_chan}, 0);
        rst = 1'b0;
        tick();
        chk("rs_break_sw_p", {24'd0, sw_p}, 32'h00);
        chk("rs_break_cur", {29'd0, cur_chan}, 6);
        wait_sample(60, cyc, wr, zr, vb);
        chk("rs_cyc", cyc, 6);
        chk("rs_sw_p", {24'd0, sw_p}, 32'h40);
        chk("rs_valid", {31'd0, valid}, 1);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
